data_memory: RTL and testbench
==============================

// Module: data_memory
//
// PURPOSE
// - Word-organised data memory for the single-cycle processor datapath; serves load/store instructions.
// - Byte-addressed 32-bit interface with word-aligned access.
// - Synchronous write on the rising clock edge; combinational read so a load completes in the same cycle.
// - Asynchronous active-low reset clears the whole array to zero.
//
// PARAMETERS
// - DATA_WIDTH  32   width of each memory word and of the data ports
// - DEPTH       256  number of words stored (byte span = 4*DEPTH); must be a power of two >= 2
// - ADDR_WIDTH  32   width of the byte address port
//
// PORTS
// - clk        in   1           rising-edge clock
// - rst_n      in   1           asynchronous active-low reset; clears every word
// - memWrite   in   1           write enable; sampled on the rising edge of clk
// - memRead    in   1           read enable; gates readData combinationally
// - address    in   ADDR_WIDTH  byte address; word index = address[log2(DEPTH)+1:2]
// - writeData  in   DATA_WIDTH  data stored on a write
// - readData   out  DATA_WIDTH  word at address while memRead=1, else 0
//
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - Reset: while rst_n=0, all DEPTH words read as 0 and writes are blocked.
//   - readData = 0 during reset regardless of memRead.
//   - Release of rst_n takes effect at the next rising edge; no write occurs on that edge unless memWrite=1 and rst_n=1.
// - Addressing:
//   - address[1:0] is ignored; accesses are always full-word, word-aligned. Address 5 maps to word 1, same as address 4.
//   - In range: address < 4*DEPTH (all bits above log2(DEPTH)+1 are zero).
//   - Out of range: writes are dropped with no wrap-around; reads return 0.
// - Write:
//   - At posedge clk with rst_n=1 and memWrite=1 and address in range, mem[index] <= writeData.
//   - The new value is visible on readData immediately after that edge (zero-cycle read latency).
// - Read:
//   - readData = memRead ? mem[index] : 0. Purely combinational, no clock latency.
//   - Follows address, memRead and memory contents within the same cycle.
// - Simultaneous memRead=1 and memWrite=1 to the same word:
//   - Before the edge, readData shows the old word.
//   - After the edge, readData shows writeData (write-first visible after edge).
// - Back-to-back writes to the same word: the last edge wins.
// - memWrite with X/Z on address: no defined write is required; implementation shall not corrupt other words in simulation where avoidable.
// - No other state exists; no handshake; every access completes in one cycle.
//
// TESTING
// - Reset: rst_n=0, memRead=1, addr=0 -> readData=0; release, read addrs 0,4,4*(DEPTH-1) -> all 0.
// - Write/read: memWrite=1, addr=0, data=32'hAABBCCDD, one edge; memWrite=0, memRead=1, addr=0 -> readData=32'hAABBCCDD.
// - Second word: write 32'h11223344 at addr=4; read addr=4 -> 32'h11223344; read addr=0 -> 32'hAABBCCDD unchanged.
// - Read gating and alignment:
//   - memRead=0, addr=4 -> readData=0.
//   - memRead=1, addr=6 -> 32'h11223344.
// - Boundaries:
//   - Write 32'hDEADBEEF at addr=4*(DEPTH-1) -> reads back.
//   - Write at addr=4*DEPTH -> dropped; reading addr=4*DEPTH gives 0; word 0 still 32'hAABBCCDD.
// - Reset mid-operation: assert rst_n=0 between edges while memWrite=1 -> readData=0 at once; after release, addrs 0 and 4 read 0.

Source files
------------

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Purpose  : Word-organised data memory. Writes are synchronous and reads are
//            combinational. An asynchronous active-low reset clears the array.
// Revision : 1.0
// ============================================================================
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memWrite,
    input  logic                  memRead,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData
);

    localparam int c_IDX_WIDTH = $clog2(DEPTH);
    localparam int c_TOP_BIT   = c_IDX_WIDTH + 2;

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [c_IDX_WIDTH-1:0] w_index;
    logic                   w_inRange;
    logic                   w_unusedByteBits;

    assign w_index          = address[c_IDX_WIDTH+1:2];
    assign w_unusedByteBits = ^address[1:0];

    // Any set bit above the word index means out of range, so there is no aliasing.
    generate
        if (ADDR_WIDTH > c_TOP_BIT) begin : g_rangeCheck
            assign w_inRange = ~|address[ADDR_WIDTH-1:c_TOP_BIT];
        end else begin : g_fullRange
            assign w_inRange = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (memWrite && w_inRange) begin
            r_mem[w_index] <= writeData;
        end
    end

    // Gating on rst_n forces a zero read immediately when reset asserts.
    assign readData = (rst_n && memRead && w_inRange) ? r_mem[w_index] : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Purpose  : Scoreboard bench for data_memory using directed vectors.
// Revision : 1.0
// ============================================================================
module tb_data_memory;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 256;
    localparam int ADDR_WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  memWrite;
    logic                  memRead;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] writeData;
    logic [DATA_WIDTH-1:0] readData;

    logic [DATA_WIDTH-1:0] expQ [$];
    string                 nameQ [$];
    logic                  sampleReq = 1'b0;
    int                    nChecks = 0;
    int                    nFails  = 0;

    data_memory #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .memWrite (memWrite),
        .memRead  (memRead),
        .address  (address),
        .writeData(writeData),
        .readData (readData)
    );

    always #5 clk = ~clk;

    // Monitor: pops one expectation each time the stimulus asks for a sample.
    always @(negedge clk) begin
        if (sampleReq) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL scoreboard_underflow: sample with no expectation, readData=%08h", readData);
            end else begin
                logic [DATA_WIDTH-1:0] e;
                string n;
                e = expQ.pop_front();
                n = nameQ.pop_front();
                nChecks++;
                if (readData !== e) begin
                    nFails++;
                    $display("FAIL %s: readData=%08h expected=%08h", n, readData, e);
                end
            end
        end
    end

    task automatic expectNow(input logic [DATA_WIDTH-1:0] e, input string n);
        expQ.push_back(e);
        nameQ.push_back(n);
        sampleReq = 1'b1;
        @(negedge clk);
        #1 sampleReq = 1'b0;
    endtask

    task automatic readAt(input logic [ADDR_WIDTH-1:0] a, input logic rd,
                          input logic [DATA_WIDTH-1:0] e, input string n);
        address = a;
        memRead = rd;
        expectNow(e, n);
    endtask

    task automatic doWrite(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        memWrite  = 1'b1;
        address   = a;
        writeData = d;
        @(posedge clk);
        #1 memWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", nChecks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        memWrite  = 1'b0;
        memRead   = 1'b1;
        address   = '0;
        writeData = '0;

        expectNow(32'h0, "reset_read_addr0");
        @(posedge clk);
        #1 rst_n = 1'b1;

        readAt(32'd0, 1'b1, 32'h0, "post_reset_addr0");
        readAt(32'd4, 1'b1, 32'h0, "post_reset_addr4");
        readAt(4 * (DEPTH - 1), 1'b1, 32'h0, "post_reset_last");

        doWrite(32'd0, 32'hAABBCCDD);
        readAt(32'd0, 1'b1, 32'hAABBCCDD, "write_read_word0");

        doWrite(32'd4, 32'h11223344);
        readAt(32'd4, 1'b1, 32'h11223344, "write_read_word1");
        readAt(32'd0, 1'b1, 32'hAABBCCDD, "word0_unchanged");

        readAt(32'd4, 1'b0, 32'h0, "read_gated_off");
        readAt(32'd6, 1'b1, 32'h11223344, "unaligned_addr6");
        readAt(32'd5, 1'b1, 32'h11223344, "unaligned_addr5");

        doWrite(4 * (DEPTH - 1), 32'hDEADBEEF);
        readAt(4 * (DEPTH - 1), 1'b1, 32'hDEADBEEF, "last_word");

        doWrite(4 * DEPTH, 32'h12345678);
        readAt(4 * DEPTH, 1'b1, 32'h0, "oob_read_zero");
        readAt(32'd0, 1'b1, 32'hAABBCCDD, "oob_no_wrap_word0");
        doWrite(32'h8000_0000, 32'hCAFEF00D);
        readAt(32'd0, 1'b1, 32'hAABBCCDD, "oob_high_bit_no_alias");

        // Same-word read and write: old value before the edge, new value after.
        @(posedge clk);
        #1;
        address   = 32'd4;
        memRead   = 1'b1;
        memWrite  = 1'b1;
        writeData = 32'h55667788;
        expectNow(32'h11223344, "rw_before_edge");
        @(posedge clk);
        #1 memWrite = 1'b0;
        expectNow(32'h55667788, "rw_after_edge");

        doWrite(32'd4, 32'h00000001);
        doWrite(32'd4, 32'h00000002);
        readAt(32'd4, 1'b1, 32'h00000002, "back_to_back_last_wins");

        // Reset asserted between edges while a write is pending.
        @(posedge clk);
        #1;
        memWrite  = 1'b1;
        memRead   = 1'b1;
        address   = 32'd0;
        writeData = 32'hFFFFFFFF;
        #2 rst_n  = 1'b0;
        expectNow(32'h0, "reset_mid_readdata");
        @(posedge clk);
        #1;
        memWrite = 1'b0;
        rst_n    = 1'b1;
        readAt(32'd0, 1'b1, 32'h0, "after_reset_addr0");
        readAt(32'd4, 1'b1, 32'h0, "after_reset_addr4");

        @(posedge clk);
        #1;
        if (expQ.size() != 0) begin
            nChecks++;
            nFails++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
